// File: rtl/dcache_wt_responder.sv
// Direct-mapped write-through no-write-allocate data cache responder.
// Define DCACHE_STATS_EN to build the read hit/miss counters.
module dcache_wt_responder #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_byte_en,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              transfer_in_progress,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W/8-1:0] mem_byte_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
);
    localparam int BE_W  = DATA_W / 8;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] rdata_q;

    logic [INDEX_W-1:0] cpu_idx, fill_idx;
    logic [TAG_W-1:0]   cpu_tag, fill_tag;
    logic idle, hit, rd_hit, rd_miss, wr_nop, wr_go, fill_done;

    assign cpu_idx  = cpu_addr[INDEX_W+1:2];
    assign cpu_tag  = cpu_addr[ADDR_W-1:INDEX_W+2];
    assign fill_idx = addr_q[INDEX_W+1:2];
    assign fill_tag = addr_q[ADDR_W-1:INDEX_W+2];

    assign idle      = (state_q == IDLE);
    assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign rd_hit    = idle && cpu_req && !cpu_rw && hit;
    assign rd_miss   = idle && cpu_req && !cpu_rw && !hit;
    assign wr_nop    = idle && cpu_req && cpu_rw && (cpu_byte_en == '0);
    assign wr_go     = idle && cpu_req && cpu_rw && (cpu_byte_en != '0);
    assign fill_done = (state_q == REFILL) && mem_ack;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rd_miss)    state_d = REFILL;
                else if (wr_go) state_d = WRITE;
            end
            REFILL:  if (mem_ack) state_d = RESP;
            WRITE:   if (mem_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        mem_req     = 1'b0;
        mem_rw      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_byte_en = '0;
        unique case (state_q)
            IDLE: begin
                if (rd_hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = data_q[cpu_idx];
                end else if (wr_nop) begin
                    cpu_ready = 1'b1;
                end
            end
            REFILL: begin
                mem_req     = 1'b1;
                mem_addr    = addr_q;
                mem_byte_en = '1;
            end
            WRITE: begin
                mem_req     = 1'b1;
                mem_rw      = 1'b1;
                mem_addr    = addr_q;
                mem_wdata   = wdata_q;
                mem_byte_en = be_q;
            end
            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = rdata_q;
            end
            default: ;
        endcase
    end

    assign transfer_in_progress = !idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            valid_q <= '0;
        end else begin
            if (rd_miss || wr_go) begin
                addr_q  <= cpu_addr & ~ADDR_W'(3);
                wdata_q <= cpu_wdata;
                be_q    <= cpu_byte_en;
            end
            if (wr_go) rdata_q <= '0;
            if (fill_done) begin
                rdata_q           <= mem_rdata;
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data need no reset: valid bits gate every lookup.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fill_done) begin
                data_q[fill_idx] <= mem_rdata;
                tag_q[fill_idx]  <= fill_tag;
            end else if (wr_go && hit) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (cpu_byte_en[b])
                        data_q[cpu_idx][8*b +: 8] <= cpu_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (rd_hit && hits_q != '1)    hits_q   <= hits_q + 32'd1;
            if (rd_miss && misses_q != '1) misses_q <= misses_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_dcache_wt_responder.sv
// Directed table-driven bench for dcache_wt_responder.
// Bench drives the memory side by hand with per-vector latency.
module tb_dcache_wt_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_rw;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byte_en;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        transfer_in_progress;
    logic        mem_req;
    logic        mem_rw;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    dcache_wt_responder dut (
        .clk(clk),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_byte_en(cpu_byte_en),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .transfer_in_progress(transfer_in_progress),
        .mem_req(mem_req),
        .mem_rw(mem_rw),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .stat_hits(stat_hits),
        .stat_misses(stat_misses)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        mem;
        int          delay;
        logic [31:0] mrdata;
        logic [31:0] exp;
        logic        drop;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        cpu_req     = 1'b1;
        cpu_rw      = v.rw;
        cpu_addr    = v.addr;
        cpu_wdata   = v.wdata;
        cpu_byte_en = v.be;
        #1;
        if (!v.mem) begin
            check("hit_ready", cpu_ready, 1);
            check("hit_mem_req", mem_req, 0);
            if (!v.rw) begin
                check("hit_rdata", cpu_rdata, v.exp);
                exp_hits++;
            end
            @(negedge clk);
            cpu_req = 1'b0;
            check("hit_tip", transfer_in_progress, 0);
            return;
        end
        check("miss_ready", cpu_ready, 0);
        if (!v.rw) exp_misses++;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!mem_req && n < 8);
        check("mem_req_latency", n, 1);
        if (!mem_req) return;
        check("mem_addr", mem_addr, v.addr & 12'hFFC);
        check("mem_rw", mem_rw, v.rw);
        check("mem_byte_en", mem_byte_en, v.rw ? v.be : 4'hF);
        check("tip_busy", transfer_in_progress, 1);
        if (v.rw) check("mem_wdata", mem_wdata, v.wdata);
        if (v.drop) cpu_req = 1'b0;
        repeat (v.delay) begin
            @(negedge clk);
            #1;
            check("wait_ready", cpu_ready, 0);
            check("wait_mem_req", mem_req, 1);
        end
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = v.mrdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        check("resp_ready", cpu_ready, 1);
        check("resp_rdata", cpu_rdata, v.rw ? 32'h0 : v.exp);
        check("resp_mem_req", mem_req, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        #1;
        check("done_ready", cpu_ready, 0);
        check("done_tip", transfer_in_progress, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int n;
        // rw addr wdata be mem delay mrdata exp drop
        vecs[0]  = '{0, 12'h010, 32'h0,        4'h0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF, 0};
        vecs[1]  = '{0, 12'h010, 32'h0,        4'h0, 0, 0, 32'h0,        32'hDEADBEEF, 0};
        vecs[2]  = '{1, 12'h010, 32'h11223344, 4'h3, 1, 1, 32'h0,        32'h0,        0};
        vecs[3]  = '{0, 12'h010, 32'h0,        4'h0, 0, 0, 32'h0,        32'hDEAD3344, 0};
        vecs[4]  = '{1, 12'h020, 32'hCAFEF00D, 4'hF, 1, 2, 32'h0,        32'h0,        0};
        vecs[5]  = '{0, 12'h020, 32'h0,        4'h0, 1, 0, 32'h12345678, 32'h12345678, 0};
        vecs[6]  = '{0, 12'h110, 32'h0,        4'h0, 1, 2, 32'hA5A5A5A5, 32'hA5A5A5A5, 1};
        vecs[7]  = '{0, 12'h010, 32'h0,        4'h0, 1, 4, 32'h0BADF00D, 32'h0BADF00D, 0};
        vecs[8]  = '{0, 12'h013, 32'h0,        4'h0, 0, 0, 32'h0,        32'h0BADF00D, 0};
        vecs[9]  = '{1, 12'h010, 32'h99999999, 4'h0, 0, 0, 32'h0,        32'h0,        0};
        vecs[10] = '{0, 12'h010, 32'h0,        4'h0, 0, 0, 32'h0,        32'h0BADF00D, 0};
        vecs[11] = '{1, 12'h012, 32'hFFEE0000, 4'hC, 1, 1, 32'h0,        32'h0,        1};
        vecs[12] = '{0, 12'h010, 32'h0,        4'h0, 0, 0, 32'h0,        32'hFFEEF00D, 0};

        reset       = 1'b1;
        cpu_req     = 1'b0;
        cpu_rw      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        cpu_byte_en = '0;
        mem_rdata   = '0;
        mem_ack     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_tip", transfer_in_progress, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_rw", mem_rw, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_byte_en", mem_byte_en, 0);
        check("rst_stat_hits", stat_hits, 0);
        check("rst_stat_misses", stat_misses, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // stray ack while idle must not start anything or disturb the array
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        check("stray_ack_tip", transfer_in_progress, 0);
        check("stray_ack_ready", cpu_ready, 0);
        run_vec(vecs[12]);

        // reset in the middle of a refill
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_rw   = 1'b0;
        cpu_addr = 12'h024;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!mem_req && n < 8);
        check("mr_mem_req", mem_req, 1);
        @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        #1;
        check("mr_mem_req_drop", mem_req, 0);
        check("mr_tip_drop", transfer_in_progress, 0);
        check("mr_ready", cpu_ready, 0);
        reset      = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        #1;
        check("late_ack_tip", transfer_in_progress, 0);
        check("late_ack_ready", cpu_ready, 0);

        v = '{0, 12'h010, 32'h0, 4'h0, 1, 2, 32'h600DCAFE, 32'h600DCAFE, 0};
        run_vec(v);
        v = '{0, 12'h010, 32'h0, 4'h0, 0, 0, 32'h0, 32'h600DCAFE, 0};
        run_vec(v);
        v = '{0, 12'h012, 32'h0, 4'h0, 0, 0, 32'h0, 32'h600DCAFE, 0};
        run_vec(v);
        v = '{0, 12'h024, 32'h0, 4'h0, 1, 0, 32'h77665544, 32'h77665544, 0};
        run_vec(v);
        v = '{0, 12'h024, 32'h0, 4'h0, 0, 0, 32'h0, 32'h77665544, 0};
        run_vec(v);

        @(negedge clk);
        #1;
`ifdef DCACHE_STATS_EN
        check("stat_hits", stat_hits, exp_hits);
        check("stat_misses", stat_misses, exp_misses);
`else
        check("stat_hits_off", stat_hits, 0);
        check("stat_misses_off", stat_misses, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_wt_responder.md
Name: dcache_wt_responder

Overview:
- CPU-side responder for the data-memory request interface driven by the pipelined datapath: direct-mapped, write-through, no-write-allocate data cache.
- Answers CPU load/store requests from a valid/tag/data array; forwards misses and all stores to a single-word memory port.
- Drives cpu_ready back to the datapath stall logic and drives transfer_in_progress while a memory transaction is open.

Parameters:
ADDR_W, 12, byte address width (matches PC/data address width)
DATA_W, 32, word width; byte_en width is DATA_W/8
INDEX_W, 6, line index bits (2**INDEX_W one-word lines)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cpu_req  in  1  request valid, held by CPU until cpu_ready
cpu_rw  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  byte address; [1:0] ignored
cpu_wdata  in  DATA_W  store data
cpu_byte_en  in  DATA_W/8  store byte lanes
cpu_rdata  out  DATA_W  load data, valid when cpu_ready
cpu_ready  out  1  request complete
transfer_in_progress  out  1  high when state != IDLE
mem_req  out  1  memory request, held until mem_ack
mem_rw  out  1  1=write
mem_addr  out  ADDR_W  word-aligned address ([1:0]=0)
mem_wdata  out  DATA_W  write data
mem_byte_en  out  DATA_W/8  write lanes; 4'hF on reads
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse
stat_hits  out  32  read-hit count (optional feature)
stat_misses  out  32  read-miss count (optional feature)

Behaviour:
- Address split: index = addr[INDEX_W+1:2]; tag = addr[ADDR_W-1:INDEX_W+2].
- Reset:
  - Clears all valid bits; state = IDLE.
  - mem_req, cpu_ready, transfer_in_progress = 0; cpu_rdata, mem_addr, mem_wdata, mem_byte_en, mem_rw = 0.
  - Reset mid-transaction aborts it; mem_req drops the next cycle and the array is invalidated.
- FSM states: IDLE, REFILL, WRITE, RESP.
- IDLE, read hit (cpu_req & !cpu_rw & valid & tag match):
  - cpu_ready = 1 combinationally in the same cycle; cpu_rdata = data[index].
  - Zero-stall hit; state stays IDLE.
- IDLE, read miss:
  - Latch request; next state REFILL.
  - Next cycle: mem_req=1, mem_rw=0, mem_addr = {addr[ADDR_W-1:2],2'b00}, mem_byte_en = 4'hF.
- IDLE, write with cpu_byte_en == 0: cpu_ready = 1 same cycle; no memory traffic, no array change.
- IDLE, write with nonzero byte_en:
  - On a hit, update only the enabled bytes of data[index] at the clock edge.
  - On a miss, leave the array untouched (no allocate).
  - Latch addr/wdata/byte_en; next state WRITE.
- REFILL: hold mem_req and address until mem_ack. On ack: write mem_rdata into data[index], set tag and valid, register it to cpu_rdata, go RESP.
- WRITE: hold mem_req, mem_rw=1, mem_wdata, mem_byte_en until mem_ack; then go RESP.
- RESP:
  - cpu_ready = 1 for exactly one cycle (registered); cpu_rdata holds the refill word (0 for writes); mem_req = 0.
  - Return to IDLE. A new request is not evaluated in RESP.
- Request drop: a latched transaction always completes even if cpu_req drops mid-operation; the RESP cpu_ready pulse is still produced.
- mem_ack outside REFILL/WRITE is ignored.
- cpu_ready is never asserted in REFILL or WRITE.
- Memory latency: unbounded; no timeout.
- Latency summary: read hit 0 cycles; read miss 2 cycles + memory latency; write 2 cycles + memory latency.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined: stat_hits increments on each IDLE read hit; stat_misses increments on each IDLE->REFILL transition. Both are 32-bit, saturate at 32'hFFFF_FFFF, and clear on reset.
- When undefined: no counter logic; stat_hits and stat_misses are tied to 0.

Test Plan:
- After reset, read addr 0x010 -> miss. mem_req asserts next cycle with mem_addr=0x010, mem_rw=0. Ack with 0xDEADBEEF after 3 cycles -> cpu_ready pulses one cycle with cpu_rdata=0xDEADBEEF. Repeat read -> same-cycle cpu_ready, no mem_req.
- With 0x010 cached, write 0x11223344 byte_en=4'b0011 -> mem write with those lanes. Next read of 0x010 hits and returns 0xDEAD3344.
- Write to uncached 0x020 -> mem write issued. Subsequent read of 0x020 misses (confirms no allocate).
- Alias test with INDEX_W=6: fill 0x010, then read 0x110 (same index, different tag) -> miss and refill. Re-read 0x010 -> miss again.
- Assert reset during REFILL before mem_ack -> mem_req=0 and transfer_in_progress=0 next cycle. A late mem_ack is ignored. Read 0x010 -> miss.
- With DCACHE_STATS_EN defined: 2 misses + 3 hits -> stat_misses=2, stat_hits=3. Without it: both read 0.
